// File: rtl/branch_redirect_if.sv
// Branch redirect interface: EX-side resolution inputs, the fetch redirect
// handshake, the pipeline flush and the performance counters.
interface branch_redirect_if #(
  parameter int XLEN  = 64,
  parameter int ID_W  = 7,
  parameter int CNT_W = 32
);
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_branch;
  logic [ID_W-1:0]  ex_instr_id;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_result;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic [XLEN-1:0]  mepc_val;
  logic             redir_valid;
  logic             redir_ready;
  logic [XLEN-1:0]  redir_pc;
  logic             flush;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  // Pipeline side: drives EX results, mepc and the fetch ready.
  modport master (
    output ex_valid, ex_branch, ex_instr_id, ex_pc, ex_imm, ex_result,
           ex_pred_taken, ex_pred_target, mepc_val, redir_ready,
    input  ex_ready, redir_valid, redir_pc, flush, branch_cnt, mispred_cnt
  );

  // Resolution unit side.
  modport slave (
    input  ex_valid, ex_branch, ex_instr_id, ex_pc, ex_imm, ex_result,
           ex_pred_taken, ex_pred_target, mepc_val, redir_ready,
    output ex_ready, redir_valid, redir_pc, flush, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Branch resolution stage after EX: resolves direction/target for conditional
// branches, jal, jalr and mret, compares against the fetch prediction, issues a
// held redirect to fetch and then a fixed-length flush. Keeps saturating
// branch and mispredict counters.
module branch_redirect_unit #(
  parameter int              XLEN         = 64,
  parameter int              ID_W         = 7,
  parameter logic [ID_W-1:0] JALR_ID      = ID_W'(23),
  parameter logic [ID_W-1:0] MRET_ID      = ID_W'(48),
  parameter int              MRET_OFS     = 4,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_redirect_if.slave    bus
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REDIR, FLUSH} state_t;

  state_t           state, state_next;
  logic [FCW-1:0]   flush_cnt;
  logic [XLEN-1:0]  redir_pc_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic             is_jalr, is_mret, taken, mispred, redirect, accept;
  logic [XLEN-1:0]  target, fallthru, resolved_pc;

  // Only branches offered while idle are accepted; everything else is wrong-path.
  assign accept = bus.ex_valid & bus.ex_branch & (state == IDLE);

  // Resolve actual direction/target and compare with the prediction.
  always_comb begin
    is_jalr  = (bus.ex_instr_id == JALR_ID);
    is_mret  = (bus.ex_instr_id == MRET_ID);
    taken    = is_jalr | is_mret | bus.ex_result[0];
    if (is_jalr)
      target = {bus.ex_result[XLEN-1:1], 1'b0};
    else if (is_mret)
      target = bus.mepc_val + XLEN'(MRET_OFS);
    else
      target = bus.ex_pc + bus.ex_imm;
    fallthru    = bus.ex_pc + XLEN'(4);
    mispred     = (taken != bus.ex_pred_taken) |
                  (taken & (target != bus.ex_pred_target));
    redirect    = mispred | is_mret;
    resolved_pc = taken ? target : fallthru;
  end

  // Next-state logic: redirect held until fetch accepts, then a timed flush.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && redirect) state_next = REDIR;
      REDIR:   if (bus.redir_ready)    state_next = FLUSH;
      FLUSH:   if (flush_cnt == '0)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, held redirect target and flush down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      redir_pc_q <= '0;
      flush_cnt  <= '0;
    end else begin
      state <= state_next;
      if (accept && redirect)
        redir_pc_q <= resolved_pc;
      if (state == REDIR && bus.redir_ready)
        flush_cnt <= FCW'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;
    end
  end

  // Saturating performance counters, updated the cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (accept) begin
      if (!(&branch_cnt_q))
        branch_cnt_q <= branch_cnt_q + 1'b1;
      if (mispred && !is_mret && !(&mispred_cnt_q))
        mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end

  assign bus.ex_ready    = (state == IDLE);
  assign bus.redir_valid = (state == REDIR);
  assign bus.flush       = (state == FLUSH);
  assign bus.redir_pc    = redir_pc_q;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed testbench for branch_redirect_unit: prediction hits/misses for
// conditional branches, jalr and mret, PC wrap, counter saturation (narrow
// counters), wrong-path inputs and asynchronous reset during a flush.
module tb_branch_redirect_unit;

  localparam int              XLEN  = 64;
  localparam int              ID_W  = 7;
  localparam int              CNT_W = 4;
  localparam int              FC    = 2;
  localparam logic [ID_W-1:0] JALR  = 7'd23;
  localparam logic [ID_W-1:0] MRET  = 7'd48;
  localparam logic [ID_W-1:0] BR    = 7'd5;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [CNT_W-1:0] exp_b;
  logic [CNT_W-1:0] exp_m;

  branch_redirect_if #(.XLEN(XLEN), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  branch_redirect_unit #(
    .XLEN(XLEN), .ID_W(ID_W), .JALR_ID(JALR), .MRET_ID(MRET),
    .MRET_OFS(4), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic check_counters(input string tag);
    check_output({tag, ".branch_cnt"}, 64'(bus.branch_cnt), 64'(exp_b));
    check_output({tag, ".mispred_cnt"}, 64'(bus.mispred_cnt), 64'(exp_m));
  endtask

  // Offer one branch for a single cycle; it is accepted if the unit is idle.
  task automatic apply_stimulus(input logic [ID_W-1:0] id, input logic [63:0] pc,
                                input logic [63:0] imm, input logic [63:0] res,
                                input logic pt, input logic [63:0] ptgt,
                                input logic [63:0] mepc);
    bus.ex_instr_id    = id;
    bus.ex_pc          = pc;
    bus.ex_imm         = imm;
    bus.ex_result      = res;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptgt;
    bus.mepc_val       = mepc;
    bus.ex_valid       = 1'b1;
    bus.ex_branch      = 1'b1;
    tick();
    bus.ex_valid       = 1'b0;
    bus.ex_branch      = 1'b0;
  endtask

  // Hold redir_ready low for n cycles while wrong-path branches are offered.
  task automatic hold_redirect(input string tag, input int n, input logic [63:0] pc);
    for (int i = 0; i < n; i++) begin
      bus.ex_valid       = 1'b1;
      bus.ex_branch      = 1'b1;
      bus.ex_instr_id    = BR;
      bus.ex_result      = 64'h1;
      bus.ex_pred_taken  = 1'b0;
      tick();
      check_output({tag, ".hold_valid"}, 64'(bus.redir_valid), 64'h1);
      check_output({tag, ".hold_pc"}, bus.redir_pc, pc);
      check_output({tag, ".hold_ready"}, 64'(bus.ex_ready), 64'h0);
    end
    bus.ex_valid  = 1'b0;
    bus.ex_branch = 1'b0;
  endtask

  // Accept the pending redirect and watch the flush window.
  task automatic complete_redirect(input string tag, input logic [63:0] pc);
    check_output({tag, ".redir_valid"}, 64'(bus.redir_valid), 64'h1);
    check_output({tag, ".redir_pc"}, bus.redir_pc, pc);
    check_output({tag, ".ex_ready_busy"}, 64'(bus.ex_ready), 64'h0);
    bus.redir_ready = 1'b1;
    tick();
    bus.redir_ready = 1'b0;
    check_output({tag, ".flush0"}, 64'(bus.flush), 64'h1);
    check_output({tag, ".valid_drop"}, 64'(bus.redir_valid), 64'h0);
    for (int i = 1; i < FC; i++) begin
      tick();
      check_output({tag, ".flushN"}, 64'(bus.flush), 64'h1);
    end
    tick();
    check_output({tag, ".flush_end"}, 64'(bus.flush), 64'h0);
    check_output({tag, ".ex_ready_back"}, 64'(bus.ex_ready), 64'h1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_b    = '0;
    exp_m    = '0;
    rst_n    = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_branch = 1'b0; bus.ex_instr_id = '0;
    bus.ex_pc = '0; bus.ex_imm = '0; bus.ex_result = '0;
    bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0; bus.mepc_val = '0;
    bus.redir_ready = 1'b0;

    $display("[TB] reset");
    tick(); tick();
    check_output("rst.redir_valid", 64'(bus.redir_valid), 64'h0);
    check_output("rst.redir_pc", bus.redir_pc, 64'h0);
    check_output("rst.flush", 64'(bus.flush), 64'h0);
    check_counters("rst");
    rst_n = 1'b1;
    tick();
    check_output("rst.ex_ready", 64'(bus.ex_ready), 64'h1);

    $display("[TB] test 1: correctly predicted taken branch");
    apply_stimulus(BR, 64'h1000, 64'h20, 64'h1, 1'b1, 64'h1020, 64'h0);
    exp_b = sat_inc(exp_b);
    check_output("t1.redir_valid", 64'(bus.redir_valid), 64'h0);
    check_output("t1.ex_ready", 64'(bus.ex_ready), 64'h1);
    check_counters("t1");

    $display("[TB] test 2: predicted not-taken, actually taken");
    apply_stimulus(BR, 64'h1000, 64'h20, 64'h1, 1'b0, 64'h0, 64'h0);
    exp_b = sat_inc(exp_b); exp_m = sat_inc(exp_m);
    check_counters("t2");
    hold_redirect("t2", 3, 64'h1020);
    complete_redirect("t2", 64'h1020);
    check_counters("t2.wrongpath");

    $display("[TB] test 3: jalr");
    apply_stimulus(JALR, 64'h1800, 64'h0, 64'h2003, 1'b1, 64'h2002, 64'h0);
    exp_b = sat_inc(exp_b);
    check_output("t3a.redir_valid", 64'(bus.redir_valid), 64'h0);
    check_counters("t3a");
    apply_stimulus(JALR, 64'h1800, 64'h0, 64'h2003, 1'b1, 64'h3000, 64'h0);
    exp_b = sat_inc(exp_b); exp_m = sat_inc(exp_m);
    check_counters("t3b");
    complete_redirect("t3b", 64'h2002);

    $display("[TB] test 4: mret always redirects");
    apply_stimulus(MRET, 64'h4000, 64'h0, 64'h0, 1'b1, 64'h8000_0004, 64'h8000_0000);
    exp_b = sat_inc(exp_b);
    check_counters("t4");
    complete_redirect("t4", 64'h8000_0004);

    $display("[TB] test 5: PC wrap and counter saturation");
    apply_stimulus(BR, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 64'h0, 1'b1, 64'hC, 64'h0);
    exp_b = sat_inc(exp_b); exp_m = sat_inc(exp_m);
    check_counters("t5a");
    complete_redirect("t5a", 64'h0);
    apply_stimulus(BR, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h1, 1'b0, 64'h0, 64'h0);
    exp_b = sat_inc(exp_b); exp_m = sat_inc(exp_m);
    complete_redirect("t5b", 64'h10);
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(BR, 64'h1000, 64'h40, 64'h1, 1'b1, 64'h1044, 64'h0);
      exp_b = sat_inc(exp_b); exp_m = sat_inc(exp_m);
      check_counters("t5.loop");
      complete_redirect("t5.loop", 64'h1040);
    end
    check_output("t5.branch_sat", 64'(bus.branch_cnt), 64'hF);
    check_output("t5.mispred_sat", 64'(bus.mispred_cnt), 64'hF);

    $display("[TB] test 6: reset during flush");
    apply_stimulus(BR, 64'h1000, 64'h20, 64'h1, 1'b0, 64'h0, 64'h0);
    bus.redir_ready = 1'b1;
    tick();
    bus.redir_ready = 1'b0;
    check_output("t6.flush_before", 64'(bus.flush), 64'h1);
    rst_n = 1'b0;
    #1;
    exp_b = '0; exp_m = '0;
    check_output("t6.flush", 64'(bus.flush), 64'h0);
    check_output("t6.redir_valid", 64'(bus.redir_valid), 64'h0);
    check_output("t6.redir_pc", bus.redir_pc, 64'h0);
    check_counters("t6");
    tick();
    rst_n = 1'b1;
    tick();
    check_output("t6.ex_ready", 64'(bus.ex_ready), 64'h1);
    apply_stimulus(BR, 64'h1000, 64'h20, 64'h1, 1'b0, 64'h0, 64'h0);
    exp_b = sat_inc(exp_b); exp_m = sat_inc(exp_m);
    hold_redirect("t6", 2, 64'h1020);
    complete_redirect("t6", 64'h1020);
    check_counters("t6.wrongpath");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
